// File: rtl/uart_fd_param.sv
// Parametrised full-duplex UART: independent TX and RX engines sharing one clock and one
// bit period, with configurable data width, parity and stop bits, plus sticky RX status flags.
module uart_fd_param #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_send,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 rx,
    input  logic                 rx_flag_clr,
    output logic                 tx_output_serial,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 rx_flag,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 overrun
);

    localparam int unsigned CntW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);

    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] StopEnd = CntW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [3:0]      LastBit = 4'(DATA_BITS - 1);
    localparam logic            HasParity = (PARITY_MODE != 0);
    localparam logic            OddParity = (PARITY_MODE == 2);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // ------------------------------------------------------------------ transmitter
    tx_state_e              tx_state_q, tx_state_d;
    logic [CntW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]             tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_line_q, tx_line_d;
    logic                   tx_busy_q, tx_busy_d;
    logic                   tx_done_q, tx_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // The line level is registered together with the state change so every bit is
    // exactly CLKS_PER_BIT cycles long.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (tx_send) begin
                    tx_shift_d = Tx_Data;
                    tx_par_d   = (^Tx_Data) ^ OddParity;
                    tx_line_d  = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + CntW'(1);
                end
            end
            TxData: begin
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LastBit) begin
                        tx_bit_d = '0;
                        if (HasParity) begin
                            tx_line_d  = tx_par_q;
                            tx_state_d = TxParity;
                        end else begin
                            tx_line_d  = 1'b1;
                            tx_state_d = TxStop;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CntW'(1);
                end
            end
            TxParity: begin
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d   = '0;
                    tx_line_d  = 1'b1;
                    tx_state_d = TxStop;
                end else begin
                    tx_cnt_d = tx_cnt_q + CntW'(1);
                end
            end
            TxStop: begin
                if (tx_cnt_q == StopEnd) begin
                    tx_cnt_d   = '0;
                    tx_done_d  = 1'b1;
                    tx_busy_d  = 1'b0;
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + CntW'(1);
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign tx_output_serial = tx_line_q;
    assign tx_busy          = tx_busy_q;
    assign tx_done          = tx_done_q;

    // ------------------------------------------------------------------ receiver
    logic                   rx_meta_q, rx_sync_q;
    rx_state_e              rx_state_q, rx_state_d;
    logic [CntW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]             rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_q, rx_par_d;
    logic                   rx_brk_q, rx_brk_d;
    logic                   rx_done;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_flag_q, rx_flag_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_brk_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_flag_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_brk_q   <= rx_brk_d;
            rx_data_q  <= rx_data_d;
            rx_flag_q  <= rx_flag_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_brk_d   = rx_brk_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                // After a low stop bit, wait for the line to recover before rearming.
                if (rx_brk_q) begin
                    if (rx_sync_q) rx_brk_d = 1'b0;
                end else if (!rx_sync_q) begin
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfEnd) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            RxData: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LastBit) begin
                        rx_bit_d   = '0;
                        rx_state_d = HasParity ? RxParity : RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            RxParity: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RxStop;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    rx_done    = 1'b1;
                    rx_brk_d   = !rx_sync_q;
                    rx_state_d = RxIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q + CntW'(1);
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // A completing frame wins over a simultaneous clear; overrun only when unacknowledged.
    always_comb begin
        rx_data_d = rx_data_q;
        rx_flag_d = rx_flag_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        if (rx_done) begin
            rx_data_d = rx_shift_q;
            perr_d    = HasParity & ((^rx_shift_q) ^ OddParity ^ rx_par_q);
            ferr_d    = !rx_sync_q;
            rx_flag_d = 1'b1;
            ovr_d     = !rx_flag_clr & (ovr_q | rx_flag_q);
        end else if (rx_flag_clr) begin
            rx_flag_d = 1'b0;
            ovr_d     = 1'b0;
        end
    end

    assign Rx_Data       = rx_data_q;
    assign rx_flag       = rx_flag_q;
    assign parity_error  = perr_q;
    assign framing_error = ferr_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_fd_param.sv
// Bench for uart_fd_param: instance A is 8N1 driven bit-by-bit, instance B is 7E2 looped back
// onto itself with an optional parity-bit corruption.
module tb_uart_fd_param;

    localparam int C = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       tx_send_a, rx_a, clr_a, tx_a, busy_a, done_a, flag_a, perr_a, ferr_a, ovr_a;
    logic [7:0] tx_data_a, rxd_a;
    logic       tx_send_b, rx_b, clr_b, tx_b, busy_b, done_b, flag_b, perr_b, ferr_b, ovr_b;
    logic [6:0] tx_data_b, rxd_b;
    logic       flip_b;

    assign rx_b = tx_b ^ flip_b;

    uart_fd_param u_a (
        .clk(clk), .rst(rst), .tx_send(tx_send_a), .Tx_Data(tx_data_a), .rx(rx_a),
        .rx_flag_clr(clr_a), .tx_output_serial(tx_a), .tx_busy(busy_a), .tx_done(done_a),
        .Rx_Data(rxd_a), .rx_flag(flag_a), .parity_error(perr_a), .framing_error(ferr_a),
        .overrun(ovr_a)
    );

    uart_fd_param #(
        .CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)
    ) u_b (
        .clk(clk), .rst(rst), .tx_send(tx_send_b), .Tx_Data(tx_data_b), .rx(rx_b),
        .rx_flag_clr(clr_b), .tx_output_serial(tx_b), .tx_busy(busy_b), .tx_done(done_b),
        .Rx_Data(rxd_b), .rx_flag(flag_b), .parity_error(perr_b), .framing_error(ferr_b),
        .overrun(ovr_b)
    );

    typedef struct packed {
        logic       sel;
        logic [8:0] data;
        logic       stop_bit;
        logic       flip;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } row_t;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    row_t rows [9];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; one serial bit per C cycles.
    task automatic send_rx_a(input logic [7:0] d, input logic stop_bit, input int hold);
        rx_a = 1'b0;
        wait_cyc(C);
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            wait_cyc(C);
        end
        rx_a = stop_bit;
        wait_cyc(C);
        if (hold > 0) wait_cyc(hold);
        rx_a = 1'b1;
        wait_cyc(2);
    endtask

    task automatic send_tx_b(input logic [6:0] d, input logic flip);
        logic seen;
        seen = 1'b0;
        tx_data_b = d;
        tx_send_b = 1'b1;
        wait_cyc(1);
        tx_send_b = 1'b0;
        if (flip) begin
            wait_cyc(C * 8);
            flip_b = 1'b1;
            wait_cyc(C);
            flip_b = 1'b0;
        end
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
        end
        check("txb_done_seen", seen, 1);
    endtask

    task automatic expect_rx(input logic sel, input int budget);
        logic seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (sel ? flag_b : flag_a) seen = 1'b1;
        end
        check("rx_flag_seen", seen, 1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            check("rx_data", sel ? {2'b0, rxd_b} : {1'b0, rxd_a}, e.data);
            check("parity_error", sel ? perr_b : perr_a, e.perr);
            check("framing_error", sel ? ferr_b : ferr_a, e.ferr);
        end
    endtask

    task automatic clear_rx(input logic sel);
        @(posedge clk);
        #1;
        if (sel) clr_b = 1'b1; else clr_a = 1'b1;
        wait_cyc(1);
        clr_a = 1'b0;
        clr_b = 1'b0;
        @(negedge clk);
        check("flag_after_clr", sel ? flag_b : flag_a, 0);
        check("ovr_after_clr", sel ? ovr_b : ovr_a, 0);
    endtask

    // Entered in the first low cycle of a frame; checks every cycle through one past tx_done.
    task automatic tx_wave(input logic sel, input logic [8:0] data, input int dbits,
                           input int pmode, input int sbits, input logic held);
        logic [15:0] fb;
        logic        p, line, busy, done, el, eb, ed;
        int          n;
        fb = '1;
        fb[0] = 1'b0;
        p = (pmode == 2);
        for (int i = 0; i < dbits; i++) begin
            fb[1 + i] = data[i];
            p ^= data[i];
        end
        if (pmode != 0) fb[1 + dbits] = p;
        n = C * (1 + dbits + ((pmode != 0) ? 1 : 0) + sbits);
        for (int c = 0; c <= n + 1; c++) begin
            @(negedge clk);
            line = sel ? tx_b : tx_a;
            busy = sel ? busy_b : busy_a;
            done = sel ? done_b : done_a;
            if (c < n) begin
                el = fb[c / C]; eb = 1'b1; ed = 1'b0;
            end else if (c == n) begin
                el = 1'b1; eb = 1'b0; ed = 1'b1;
            end else begin
                el = !held; eb = held; ed = 1'b0;
            end
            check("tx_line", line, el);
            check("tx_busy", busy, eb);
            check("tx_done", done, ed);
        end
    endtask

    initial begin
        tx_send_a = 0; tx_data_a = '0; rx_a = 1; clr_a = 0;
        tx_send_b = 0; tx_data_b = '0; clr_b = 0; flip_b = 0;

        rows[0] = '{sel:0, data:9'h055, stop_bit:1, flip:0, exp_data:9'h055, exp_perr:0, exp_ferr:0};
        rows[1] = '{sel:0, data:9'h000, stop_bit:1, flip:0, exp_data:9'h000, exp_perr:0, exp_ferr:0};
        rows[2] = '{sel:0, data:9'h0FF, stop_bit:1, flip:0, exp_data:9'h0FF, exp_perr:0, exp_ferr:0};
        rows[3] = '{sel:0, data:9'h03C, stop_bit:0, flip:0, exp_data:9'h03C, exp_perr:0, exp_ferr:1};
        rows[4] = '{sel:0, data:9'h0A5, stop_bit:1, flip:0, exp_data:9'h0A5, exp_perr:0, exp_ferr:0};
        rows[5] = '{sel:1, data:9'h035, stop_bit:1, flip:0, exp_data:9'h035, exp_perr:0, exp_ferr:0};
        rows[6] = '{sel:1, data:9'h035, stop_bit:1, flip:1, exp_data:9'h035, exp_perr:1, exp_ferr:0};
        rows[7] = '{sel:1, data:9'h07F, stop_bit:1, flip:0, exp_data:9'h07F, exp_perr:0, exp_ferr:0};
        rows[8] = '{sel:1, data:9'h001, stop_bit:1, flip:1, exp_data:9'h001, exp_perr:1, exp_ferr:0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_a", tx_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_rxd_a", rxd_a, 0);
        check("rst_flags_a", {flag_a, perr_a, ferr_a, ovr_a}, 0);
        check("rst_tx_b", tx_b, 1);
        check("rst_flags_b", {busy_b, done_b, flag_b, perr_b, ferr_b, ovr_b}, 0);
        rst = 1'b0;
        wait_cyc(4);

        // 8N1 transmit waveform of 0xA5
        tx_data_a = 8'hA5;
        tx_send_a = 1'b1;
        wait_cyc(1);
        tx_send_a = 1'b0;
        tx_wave(0, 9'h0A5, 8, 0, 1, 0);

        // Table-driven receive frames
        for (int r = 0; r < 9; r++) begin
            wait_cyc(3);
            sb.push_back({rows[r].exp_data, rows[r].exp_perr, rows[r].exp_ferr});
            if (!rows[r].sel) begin
                send_rx_a(rows[r].data[7:0], rows[r].stop_bit, 0);
                expect_rx(0, 50);
                clear_rx(0);
            end else begin
                send_tx_b(rows[r].data[6:0], rows[r].flip);
                expect_rx(1, 50);
                clear_rx(1);
            end
        end

        // Framing error with the line held low afterwards: exactly one frame
        wait_cyc(3);
        sb.push_back({9'h03C, 1'b0, 1'b1});
        send_rx_a(8'h3C, 0, 100);
        expect_rx(0, 10);
        check("break_no_overrun", ovr_a, 0);
        clear_rx(0);
        check("ferr_holds_after_clr", ferr_a, 1);
        check("rxd_holds_after_clr", rxd_a, 8'h3C);

        // Overrun: two frames without acknowledging
        wait_cyc(3);
        send_rx_a(8'h11, 1, 0);
        send_rx_a(8'h22, 1, 0);
        @(negedge clk);
        check("ovr_flag", flag_a, 1);
        check("ovr_set", ovr_a, 1);
        check("ovr_rxd_second", rxd_a, 8'h22);
        check("ovr_ferr", ferr_a, 0);
        clear_rx(0);

        // Clear coincident with completion: set wins, no overrun
        wait_cyc(3);
        send_rx_a(8'h33, 1, 0);
        @(negedge clk);
        check("pre_flag", flag_a, 1);
        check("pre_ovr", ovr_a, 0);
        wait_cyc(1);
        fork
            send_rx_a(8'h44, 1, 0);
            begin
                wait_cyc(154);
                clr_a = 1'b1;
                wait_cyc(1);
                clr_a = 1'b0;
            end
        join
        @(negedge clk);
        check("coinc_flag", flag_a, 1);
        check("coinc_ovr", ovr_a, 0);
        check("coinc_rxd", rxd_a, 8'h44);
        clear_rx(0);

        // 5-cycle glitch is rejected
        wait_cyc(3);
        rx_a = 1'b0;
        wait_cyc(5);
        rx_a = 1'b1;
        wait_cyc(40);
        @(negedge clk);
        check("glitch_flag", flag_a, 0);
        check("glitch_rxd", rxd_a, 8'h44);
        wait_cyc(1);
        sb.push_back({9'h096, 1'b0, 1'b0});
        send_rx_a(8'h96, 1, 0);
        expect_rx(0, 10);
        clear_rx(0);

        // 7E2 back-to-back with tx_send held, then reset mid-DATA
        wait_cyc(3);
        tx_data_b = 7'h35;
        tx_send_b = 1'b1;
        wait_cyc(1);
        tx_wave(1, 9'h035, 7, 1, 2, 1);
        repeat (40) @(negedge clk);
        tx_send_b = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_tx_line", tx_b, 1);
        check("rst_mid_busy", busy_b, 0);
        check("rst_mid_done", done_b, 0);
        check("rst_mid_flag_b", flag_b, 0);
        check("rst_mid_rxd_b", rxd_b, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(C * 2);
        @(negedge clk);
        check("post_rst_line", tx_b, 1);
        check("post_rst_busy", busy_b, 0);
        check("post_rst_flag_b", flag_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
